// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
//   Read-side controller for the 8-entry, 4-bit register-file FIFO.
//   Owns the read pointer, selects one word from the flattened register-file
//   contents and registers it onto dout. Reports the outcome of each read
//   request for one cycle through rd_ack / rd_err. Occupancy is owned by the
//   write side and arrives on data_count.
//
//   Ports
//     clk         in   rising-edge clock
//     reset_n     in   asynchronous active-low reset
//     rd_en       in   read request, sampled on the rising edge
//     data_count  in   occupancy from the write side (0..2^AW)
//     mem_flat    in   register-file contents, entry k at [k*WIDTH +: WIDTH]
//     rd_ptr      out  address of the next entry to read
//     dout        out  registered read data
//     rd_ack      out  previous-cycle read succeeded (one cycle)
//     rd_err      out  previous-cycle read rejected, FIFO empty (one cycle)
//     empty       out  combinational, data_count == 0
//     rd_pop      out  combinational, rd_en & ~empty; write side decrements on it
//
//   state    | meaning
//   ---------+----------------------------------------------
//   INIT     | held in reset, left on first edge after release
//   NO_OP    | no request last edge
//   READ     | last request succeeded
//   RD_ERROR | last request rejected (FIFO empty)

module fifo_rd_ctrl #(
    parameter int WIDTH = 4,
    parameter int AW    = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rd_en,
    input  logic [AW:0]                   data_count,
    input  logic [WIDTH*(2**AW)-1:0]      mem_flat,
    output logic [AW-1:0]                 rd_ptr,
    output logic [WIDTH-1:0]              dout,
    output logic                          rd_ack,
    output logic                          rd_err,
    output logic                          empty,
    output logic                          rd_pop
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_NO_OP    = 2'd1,
        ST_READ     = 2'd2,
        ST_RD_ERROR = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [WIDTH-1:0]   mem_words [DEPTH];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            mem_words[k] = mem_flat[k*WIDTH +: WIDTH];
        end
    end

    // Counts 9..15 are illegal; comparing against zero alone makes them
    // read as non-empty.
    assign empty  = (data_count == '0);
    assign rd_pop = rd_en & ~empty;

    // Next state does not depend on the current state: every edge simply
    // classifies the request seen on that edge.
    always_comb begin
        state_d  = ST_NO_OP;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (rd_en) begin
            if (empty) begin
                state_d = ST_RD_ERROR;
            end else begin
                state_d  = ST_READ;
                dout_d   = mem_words[rd_ptr_q];
                // Pointer width equals AW, so the increment wraps 7 -> 0.
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_INIT;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    // The state register is itself loaded from the next state, so decoding
    // it directly gives registered, mutually exclusive one-cycle strobes.
    assign rd_ack = (state_q == ST_READ);
    assign rd_err = (state_q == ST_RD_ERROR);
    assign rd_ptr = rd_ptr_q;
    assign dout   = dout_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

    logic        clk;
    logic        reset_n;
    logic        rd_en;
    logic [3:0]  data_count;
    logic [31:0] mem_flat;
    logic [2:0]  rd_ptr;
    logic [3:0]  dout;
    logic        rd_ack;
    logic        rd_err;
    logic        empty;
    logic        rd_pop;

    int checks   = 0;
    int failures = 0;

    // Reference model: the observable result of the most recent edge.
    int         m_ptr;
    logic [3:0] m_dout;
    logic       m_ack;
    logic       m_err;

    fifo_rd_ctrl #(.WIDTH(4), .AW(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_en      (rd_en),
        .data_count (data_count),
        .mem_flat   (mem_flat),
        .rd_ptr     (rd_ptr),
        .dout       (dout),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .empty      (empty),
        .rd_pop     (rd_pop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_dout = 4'h0;
        m_ack  = 1'b0;
        m_err  = 1'b0;
    endtask

    // One request is judged purely by occupancy before the edge.
    task automatic model_edge();
        if (rd_en && data_count != 0) begin
            m_dout = 4'((mem_flat >> (m_ptr * 4)) & 32'hF);
            m_ptr  = (m_ptr + 1) % 8;
            m_ack  = 1'b1;
            m_err  = 1'b0;
        end else if (rd_en) begin
            m_ack = 1'b0;
            m_err = 1'b1;
        end else begin
            m_ack = 1'b0;
            m_err = 1'b0;
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_dout"},   32'(dout),   32'(m_dout));
        chk({tag, "_rd_ptr"}, 32'(rd_ptr), 32'(m_ptr));
        chk({tag, "_rd_ack"}, 32'(rd_ack), 32'(m_ack));
        chk({tag, "_rd_err"}, 32'(rd_err), 32'(m_err));
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic step(input string tag);
        #1;
        chk({tag, "_empty"},  32'(empty),  32'(data_count == 0));
        chk({tag, "_rd_pop"}, 32'(rd_pop), 32'(rd_en && data_count != 0));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_regs(tag);
    endtask

    // Asserts reset mid-cycle, checks the immediate clear, holds for n edges.
    task automatic pulse_reset(input string tag, input int n);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_regs({tag, "_async"});
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_regs({tag, "_release"});
    endtask

    initial begin
        reset_n    = 1'b0;
        rd_en      = 1'b0;
        data_count = 4'd0;
        mem_flat   = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_regs("por");
        reset_n = 1'b1;

        for (int i = 0; i < 3; i++) step("idle");

        // Single read of entry 0.
        mem_flat   = 32'h0000_000A;
        data_count = 4'd1;
        rd_en      = 1'b1;
        step("single");
        chk("single_dout_A", 32'(dout), 32'hA);
        chk("single_ptr_1", 32'(rd_ptr), 32'd1);
        rd_en = 1'b0;
        data_count = 4'd0;
        step("single_after");
        chk("single_ack_drop", 32'(rd_ack), 32'd0);

        // Load dout with 5 from entry 1, then read while empty.
        mem_flat   = 32'h0000_0050;
        data_count = 4'd1;
        rd_en      = 1'b1;
        step("pre_empty");
        data_count = 4'd0;
        step("empty_read");
        chk("empty_err", 32'(rd_err), 32'd1);
        chk("empty_dout_hold", 32'(dout), 32'h5);
        chk("empty_ptr_hold", 32'(rd_ptr), 32'd2);

        // Wrap-around from a fresh pointer.
        rd_en = 1'b0;
        pulse_reset("wrap_rst", 1);
        mem_flat = 32'h7654_3210;
        rd_en    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_count = 4'(8 - i);
            step("wrap");
            chk("wrap_dout_seq", 32'(dout), 32'(i));
        end
        chk("wrap_ptr_zero", 32'(rd_ptr), 32'd0);
        data_count = 4'd0;
        step("wrap_ninth");
        chk("wrap_ninth_err", 32'(rd_err), 32'd1);
        chk("wrap_ninth_dout", 32'(dout), 32'h7);

        // Reset in the middle of a burst.
        mem_flat   = 32'hFEDC_BA98;
        data_count = 4'd8;
        for (int i = 0; i < 3; i++) step("burst");
        rd_en = 1'b0;
        pulse_reset("burst_rst", 2);
        chk("burst_rst_ptr", 32'(rd_ptr), 32'd0);
        chk("burst_rst_dout", 32'(dout), 32'd0);
        rd_en = 1'b1;
        step("after_rst");
        chk("after_rst_entry0", 32'(dout), 32'h8);

        // Randomised traffic against the model, occasional resets.
        for (int i = 0; i < 300; i++) begin
            rd_en      = 1'($urandom_range(0, 1));
            data_count = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 8));
            mem_flat   = $urandom;
            if ($urandom_range(0, 59) == 0) begin
                pulse_reset("rand_rst", $urandom_range(1, 2));
            end
            step("rand");
            chk("rand_excl", 32'(rd_ack & rd_err), 32'd0);
        end

        rd_en = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
